// File: rtl/aerin_spike_tx.sv
// Rate-encoding AER transmitter: scans the sample buffer once per timestep, turns each
// pixel into a Bernoulli spike via an LFSR compare, and emits 4-phase AER events plus an EOT marker.
module aerin_spike_tx #(
  parameter int              TIME_STEP      = 8,
  parameter int              INPUT_NEURON   = 784,
  parameter int              AER_WIDTH      = 12,
  parameter int              PIX_ADDR_WIDTH = 10,
  parameter logic [AER_WIDTH-1:0] EOT_ADDR  = 12'hFFF,
  parameter logic [15:0]     LFSR_SEED      = 16'hACE1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      START,
  output logic                      PIX_RD_EN,
  output logic [PIX_ADDR_WIDTH-1:0] PIX_ADDR,
  input  logic [7:0]                PIX_DATA,
  output logic [AER_WIDTH-1:0]      AERIN_ADDR,
  output logic                      AERIN_REQ,
  input  logic                      AERIN_ACK,
  output logic                      BUSY,
  output logic                      DONE,
  output logic [15:0]               EVT_CNT
);

  localparam int T_W = (TIME_STEP > 1) ? $clog2(TIME_STEP) : 1;
  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [PIX_ADDR_WIDTH-1:0] N_LAST = PIX_ADDR_WIDTH'(INPUT_NEURON - 1);
  localparam logic [T_W-1:0]            T_LAST = T_W'(TIME_STEP - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EVAL, S_REQ_HI, S_REQ_LO, S_EOT_HI, S_EOT_LO, S_FINISH
  } state_t;

  state_t                      state, state_nxt;
  logic [PIX_ADDR_WIDTH-1:0]   n, n_nxt;
  logic [T_W-1:0]              t, t_nxt;
  logic [15:0]                 lfsr, lfsr_nxt;
  logic [15:0]                 cnt, cnt_nxt;
  logic [AER_WIDTH-1:0]        addr_q, addr_nxt;
  logic                        req_q, req_nxt;
  logic                        adv;

  // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci, shifting left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    t_nxt     = t;
    lfsr_nxt  = lfsr;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    req_nxt   = req_q;
    adv       = 1'b0;
    case (state)
      S_IDLE: begin
        if (START) begin
          lfsr_nxt  = SEED;
          n_nxt     = '0;
          t_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: state_nxt = S_EVAL;
      S_EVAL: begin
        lfsr_nxt = lfsr_step(lfsr);
        if (PIX_DATA > lfsr[7:0]) begin
          addr_nxt  = AER_WIDTH'(n);
          req_nxt   = 1'b1;
          state_nxt = S_REQ_HI;
        end else begin
          adv = 1'b1;
        end
      end
      S_REQ_HI: begin
        if (AERIN_ACK) begin
          req_nxt   = 1'b0;
          cnt_nxt   = sat_inc(cnt);
          state_nxt = S_REQ_LO;
        end
      end
      S_REQ_LO: adv = !AERIN_ACK;
      S_EOT_HI: begin
        if (AERIN_ACK) begin
          req_nxt   = 1'b0;
          state_nxt = S_EOT_LO;
        end
      end
      S_EOT_LO: begin
        if (!AERIN_ACK) begin
          if (t < T_LAST) begin
            t_nxt     = t + T_W'(1);
            n_nxt     = '0;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_FINISH;
          end
        end
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    // Step to the next neuron, or close the timestep with the EOT marker.
    if (adv) begin
      if (n < N_LAST) begin
        n_nxt     = n + PIX_ADDR_WIDTH'(1);
        state_nxt = S_FETCH;
      end else begin
        addr_nxt  = EOT_ADDR;
        req_nxt   = 1'b1;
        state_nxt = S_EOT_HI;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= S_IDLE;
      n      <= '0;
      t      <= '0;
      lfsr   <= SEED;
      cnt    <= '0;
      addr_q <= '0;
      req_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      n      <= n_nxt;
      t      <= t_nxt;
      lfsr   <= lfsr_nxt;
      cnt    <= cnt_nxt;
      addr_q <= addr_nxt;
      req_q  <= req_nxt;
    end
  end

  assign PIX_RD_EN  = (state == S_FETCH);
  assign PIX_ADDR   = (state == S_FETCH) ? n : '0;
  assign AERIN_ADDR = addr_q;
  assign AERIN_REQ  = req_q;
  assign BUSY       = (state != S_IDLE) && (state != S_FINISH);
  assign DONE       = (state == S_FINISH);
  assign EVT_CNT    = cnt;

endmodule

// File: tb/tb_aerin_spike_tx.sv
// Bench for aerin_spike_tx: two instances (64x8 seed ACE1, 4x2 seed 0) against a
// queue-based reference of the spike/EOT event stream.
module tb_aerin_spike_tx;

  logic        clk, rst;
  logic        start [2];
  logic        rd_en [2];
  logic [9:0]  pix_addr [2];
  logic [7:0]  pix_data [2];
  logic [11:0] addr [2];
  logic        req [2];
  logic        ack [2];
  logic        busy [2];
  logic        done [2];
  logic [15:0] evt_cnt [2];

  logic [7:0]  mem [2][64];
  logic        ack_r [2];
  int          rcnt [2];
  int          dly [2], rdly [2];
  bit          stall [2], inst [2];

  logic        prev_req [2];
  logic [11:0] prev_addr [2];
  bit          lo_seen [2];
  int          done_cnt [2];
  int          got_q[$], exp_q[$];
  int          n_chk, n_pass;

  aerin_spike_tx #(.TIME_STEP(8), .INPUT_NEURON(64), .LFSR_SEED(16'hACE1)) u_dut0 (
    .CLK(clk), .RST(rst), .START(start[0]), .PIX_RD_EN(rd_en[0]), .PIX_ADDR(pix_addr[0]),
    .PIX_DATA(pix_data[0]), .AERIN_ADDR(addr[0]), .AERIN_REQ(req[0]), .AERIN_ACK(ack[0]),
    .BUSY(busy[0]), .DONE(done[0]), .EVT_CNT(evt_cnt[0]));

  aerin_spike_tx #(.TIME_STEP(2), .INPUT_NEURON(4), .LFSR_SEED(16'h0000)) u_dut1 (
    .CLK(clk), .RST(rst), .START(start[1]), .PIX_RD_EN(rd_en[1]), .PIX_ADDR(pix_addr[1]),
    .PIX_DATA(pix_data[1]), .AERIN_ADDR(addr[1]), .AERIN_REQ(req[1]), .AERIN_ACK(ack[1]),
    .BUSY(busy[1]), .DONE(done[1]), .EVT_CNT(evt_cnt[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ack[0] = inst[0] ? req[0] : ack_r[0];
  assign ack[1] = inst[1] ? req[1] : ack_r[1];

  // Sample buffer and registered 4-phase receivers.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd_en[i]) pix_data[i] <= mem[i][pix_addr[i][5:0]];
      if (rst) begin
        ack_r[i] <= 1'b0;
        rcnt[i]  <= 0;
      end else if (!ack_r[i]) begin
        if (req[i] && !stall[i]) begin
          if (rcnt[i] >= dly[i]) begin ack_r[i] <= 1'b1; rcnt[i] <= 0; end
          else rcnt[i] <= rcnt[i] + 1;
        end else rcnt[i] <= 0;
      end else if (!req[i]) begin
        if (rcnt[i] >= rdly[i]) begin ack_r[i] <= 1'b0; rcnt[i] <= 0; end
        else rcnt[i] <= rcnt[i] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Event monitor: records every REQ rise and checks handshake rules.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        prev_req[i] = 1'b0;
        lo_seen[i]  = 1'b1;
      end else begin
        if (req[i] && !prev_req[i]) begin
          chk("req_reassert_before_ack_low", 32'(lo_seen[i]), 32'd1);
          lo_seen[i] = 1'b0;
          got_q.push_back(int'(addr[i]));
        end else if (req[i] && prev_req[i]) begin
          chk("addr_stable_during_req", 32'(addr[i]), 32'(prev_addr[i]));
        end
        if (!req[i] && !ack[i]) lo_seen[i] = 1'b1;
        if (done[i]) done_cnt[i]++;
      end
      prev_req[i]  = req[i];
      prev_addr[i] = addr[i];
    end
  end

  // Reference: each timestep scans every neuron, one LFSR draw per neuron, then an EOT marker.
  function automatic int build_model(input int i);
    logic [15:0] l;
    int in_n, ts_n, cnt;
    in_n = (i == 0) ? 64 : 4;
    ts_n = (i == 0) ? 8 : 2;
    l    = (i == 0) ? 16'hACE1 : 16'h0000;
    if (l == 16'h0000) l = 16'h0001;
    cnt  = 0;
    exp_q.delete();
    for (int t = 0; t < ts_n; t++) begin
      for (int n = 0; n < in_n; n++) begin
        bit sp;
        sp = (mem[i][n] > l[7:0]);
        l  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        if (sp) begin exp_q.push_back(n); cnt++; end
      end
      exp_q.push_back(12'hFFF);
    end
    return cnt;
  endfunction

  task automatic run_sample(input int i, input int extra_at);
    int  n_exp;
    bit  fin;
    n_exp = build_model(i);
    got_q.delete();
    done_cnt[i] = 0;
    @(posedge clk); #1 start[i] = 1'b1;
    @(posedge clk); #1 start[i] = 1'b0;
    fin = 0;
    for (int c = 1; c < 20000; c++) begin
      @(posedge clk); #1;
      start[i] = (extra_at != 0 && c == extra_at);
      if (done[i]) begin fin = 1; break; end
    end
    start[i] = 1'b0;
    chk("done_within_budget", 32'(fin), 32'd1);
    chk("evt_cnt", 32'(evt_cnt[i]), 32'(n_exp));
    chk("event_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      if (k < got_q.size()) chk("event_addr", 32'(got_q[k]), 32'(exp_q[k]));
    repeat (2) @(posedge clk);
    #1;
    chk("busy_after_done", 32'(busy[i]), 32'd0);
    chk("done_pulse_count", 32'(done_cnt[i]), 32'd1);
    chk("evt_cnt_holds", 32'(evt_cnt[i]), 32'(n_exp));
  endtask

  initial begin
    int lit [6];
    bit hit;
    n_chk = 0; n_pass = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; dly[i] = 0; rdly[i] = 0; stall[i] = 0; done_cnt[i] = 0;
    end
    inst[0] = 0; inst[1] = 1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(req[0]), 32'd0);
    chk("rst_addr", 32'(addr[0]), 32'd0);
    chk("rst_rd_en", 32'(rd_en[0]), 32'd0);
    chk("rst_pix_addr", 32'(pix_addr[0]), 32'd0);
    chk("rst_busy", 32'(busy[0]), 32'd0);
    chk("rst_done", 32'(done[0]), 32'd0);
    chk("rst_evt_cnt", 32'(evt_cnt[0]), 32'd0);
    rst = 1'b0;

    // All-zero pixels: only the 8 EOT markers.
    for (int k = 0; k < 64; k++) mem[0][k] = 8'd0;
    run_sample(0, 0);
    chk("zero_pix_events", 32'(got_q.size()), 32'd8);

    // Random pixels, one-cycle receiver.
    for (int k = 0; k < 64; k++) mem[0][k] = 8'($urandom_range(0, 255));
    run_sample(0, 0);

    // Saturated pixels: nearly every draw spikes.
    for (int k = 0; k < 64; k++) mem[0][k] = 8'd255;
    run_sample(0, 0);

    // Slow receiver on both edges of the handshake.
    dly[0] = 6; rdly[0] = 6;
    for (int k = 0; k < 64; k++) mem[0][k] = 8'($urandom_range(0, 255));
    run_sample(0, 0);
    dly[0] = 0; rdly[0] = 0;

    // Second START while busy must be ignored.
    run_sample(0, 40);

    // Reset while stalled in REQ_HI, then a clean restart.
    dly[0] = 3;
    for (int k = 0; k < 64; k++) mem[0][k] = 8'($urandom_range(160, 255));
    got_q.delete();
    @(posedge clk); #1 start[0] = 1'b1;
    @(posedge clk); #1 start[0] = 1'b0;
    hit = 0;
    for (int c = 0; c < 5000; c++) begin
      @(posedge clk); #1;
      if (got_q.size() >= 3) begin stall[0] = 1; hit = 1; break; end
    end
    chk("reach_third_event", 32'(hit), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("stalled_req", 32'(req[0]), 32'd1);
    chk("stalled_ack", 32'(ack[0]), 32'd0);
    chk("stalled_evt_cnt", 32'(evt_cnt[0]), 32'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_req", 32'(req[0]), 32'd0);
    chk("midrst_busy", 32'(busy[0]), 32'd0);
    chk("midrst_evt_cnt", 32'(evt_cnt[0]), 32'd0);
    rst = 1'b0; stall[0] = 0; dly[0] = 0;
    run_sample(0, 0);

    // Small instance, seed 0 (runs from 1), pixels {255,0,0,255}, instantaneous ACK.
    mem[1][0] = 8'd255; mem[1][1] = 8'd0; mem[1][2] = 8'd0; mem[1][3] = 8'd255;
    run_sample(1, 0);
    lit = '{0, 3, 4095, 0, 3, 4095};
    chk("small_event_count", 32'(got_q.size()), 32'd6);
    for (int k = 0; k < 6; k++)
      if (k < got_q.size()) chk("small_event_addr", 32'(got_q[k]), 32'(lit[k]));
    chk("small_evt_cnt", 32'(evt_cnt[1]), 32'd4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
